// File: rtl/mem_xfer.sv
// CHIP-8 memory-bus initiator: sequences opcode fetch, register load/store and BCD store
// over the byte-wide memory read/write ports with a full four-phase read handshake.
`timescale 1ns / 1ps

module mem_xfer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  cmd_i,
  input  logic [11:0] base_i,
  input  logic [3:0]  count_i,
  input  logic [7:0]  value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] opcode_o,
  output logic        mem_read_o,
  output logic [11:0] mem_read_addr_o,
  input  logic [7:0]  mem_read_data_i,
  input  logic        mem_read_ack_i,
  output logic        mem_write_o,
  output logic [11:0] mem_write_addr_o,
  output logic [7:0]  mem_write_data_o,
  output logic [3:0]  reg_raddr_o,
  input  logic [7:0]  reg_rdata_i,
  output logic        reg_we_o,
  output logic [3:0]  reg_waddr_o,
  output logic [7:0]  reg_wdata_o
);

  localparam logic [1:0] CmdFetch = 2'd0;
  localparam logic [1:0] CmdLoad  = 2'd1;
  localparam logic [1:0] CmdStore = 2'd2;
  localparam logic [1:0] CmdBcd   = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdRel,
    StWr,
    StWrGap,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  last_q, last_d;
  logic [3:0]  dig_hun_q, dig_hun_d;
  logic [3:0]  dig_ten_q, dig_ten_d;
  logic [3:0]  dig_one_q, dig_one_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] opcode_q, opcode_d;
  logic        mem_read_q, mem_read_d;
  logic [11:0] mem_read_addr_q, mem_read_addr_d;
  logic        mem_write_q, mem_write_d;
  logic [11:0] mem_write_addr_q, mem_write_addr_d;
  logic [7:0]  mem_write_data_q, mem_write_data_d;
  logic [3:0]  reg_raddr_q, reg_raddr_d;
  logic        reg_we_q, reg_we_d;
  logic [3:0]  reg_waddr_q, reg_waddr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;

  logic [3:0]  idx_nxt;
  logic [11:0] addr_nxt;
  logic [3:0]  dig_sel;

  assign idx_nxt  = idx_q + 4'd1;
  assign addr_nxt = base_q + {8'd0, idx_nxt};

  always_comb begin
    dig_sel = dig_one_q;
    unique case (idx_nxt[1:0])
      2'd0:    dig_sel = dig_hun_q;
      2'd1:    dig_sel = dig_ten_q;
      default: dig_sel = dig_one_q;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    base_d           = base_q;
    idx_d            = idx_q;
    last_d           = last_q;
    dig_hun_d        = dig_hun_q;
    dig_ten_d        = dig_ten_q;
    dig_one_d        = dig_one_q;
    opcode_d         = opcode_q;
    mem_read_d       = 1'b0;
    mem_read_addr_d  = mem_read_addr_q;
    mem_write_d      = 1'b0;
    mem_write_addr_d = mem_write_addr_q;
    mem_write_data_d = mem_write_data_q;
    reg_raddr_d      = reg_raddr_q;
    reg_we_d         = 1'b0;
    reg_waddr_d      = reg_waddr_q;
    reg_wdata_d      = reg_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cmd_d     = cmd_i;
          base_d    = base_i;
          idx_d     = 4'd0;
          dig_hun_d = 4'(value_i / 8'd100);
          dig_ten_d = 4'((value_i / 8'd10) % 8'd10);
          dig_one_d = 4'(value_i % 8'd10);
          unique case (cmd_i)
            CmdFetch: last_d = 4'd1;
            CmdBcd:   last_d = 4'd2;
            default:  last_d = count_i;
          endcase
          if (cmd_i == CmdFetch || cmd_i == CmdLoad) begin
            state_d         = StRd;
            mem_read_d      = 1'b1;
            mem_read_addr_d = base_i;
          end else begin
            // reg_raddr is parked at 0 in idle, so reg_rdata already holds V0 here
            state_d          = StWr;
            mem_write_d      = 1'b1;
            mem_write_addr_d = base_i;
            mem_write_data_d = (cmd_i == CmdStore) ? reg_rdata_i
                                                   : {4'd0, 4'(value_i / 8'd100)};
          end
        end
      end

      StRd: begin
        mem_read_d = 1'b1;
        if (mem_read_ack_i) begin
          mem_read_d = 1'b0;
          state_d    = StRdRel;
          if (cmd_q == CmdFetch) begin
            if (idx_q == 4'd0) begin
              opcode_d[15:8] = mem_read_data_i;
            end else begin
              opcode_d[7:0] = mem_read_data_i;
            end
          end else begin
            reg_we_d    = 1'b1;
            reg_waddr_d = idx_q;
            reg_wdata_d = mem_read_data_i;
          end
        end
      end

      StRdRel: begin
        if (!mem_read_ack_i) begin
          if (idx_q == last_q) begin
            state_d = StDone;
          end else begin
            idx_d           = idx_nxt;
            state_d         = StRd;
            mem_read_d      = 1'b1;
            mem_read_addr_d = addr_nxt;
          end
        end
      end

      StWr: begin
        state_d = StWrGap;
        // Present the next register index a cycle early so its data is ready on re-entry
        reg_raddr_d = idx_nxt;
      end

      StWrGap: begin
        if (idx_q == last_q) begin
          state_d = StDone;
        end else begin
          idx_d            = idx_nxt;
          state_d          = StWr;
          mem_write_d      = 1'b1;
          mem_write_addr_d = addr_nxt;
          mem_write_data_d = (cmd_q == CmdStore) ? reg_rdata_i : {4'd0, dig_sel};
        end
      end

      StDone: begin
        state_d     = StIdle;
        idx_d       = 4'd0;
        reg_raddr_d = 4'd0;
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      cmd_q            <= CmdFetch;
      base_q           <= 12'd0;
      idx_q            <= 4'd0;
      last_q           <= 4'd0;
      dig_hun_q        <= 4'd0;
      dig_ten_q        <= 4'd0;
      dig_one_q        <= 4'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      opcode_q         <= 16'h0000;
      mem_read_q       <= 1'b0;
      mem_read_addr_q  <= 12'd0;
      mem_write_q      <= 1'b0;
      mem_write_addr_q <= 12'd0;
      mem_write_data_q <= 8'd0;
      reg_raddr_q      <= 4'd0;
      reg_we_q         <= 1'b0;
      reg_waddr_q      <= 4'd0;
      reg_wdata_q      <= 8'd0;
    end else begin
      state_q          <= state_d;
      cmd_q            <= cmd_d;
      base_q           <= base_d;
      idx_q            <= idx_d;
      last_q           <= last_d;
      dig_hun_q        <= dig_hun_d;
      dig_ten_q        <= dig_ten_d;
      dig_one_q        <= dig_one_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      opcode_q         <= opcode_d;
      mem_read_q       <= mem_read_d;
      mem_read_addr_q  <= mem_read_addr_d;
      mem_write_q      <= mem_write_d;
      mem_write_addr_q <= mem_write_addr_d;
      mem_write_data_q <= mem_write_data_d;
      reg_raddr_q      <= reg_raddr_d;
      reg_we_q         <= reg_we_d;
      reg_waddr_q      <= reg_waddr_d;
      reg_wdata_q      <= reg_wdata_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign opcode_o         = opcode_q;
  assign mem_read_o       = mem_read_q;
  assign mem_read_addr_o  = mem_read_addr_q;
  assign mem_write_o      = mem_write_q;
  assign mem_write_addr_o = mem_write_addr_q;
  assign mem_write_data_o = mem_write_data_q;
  assign reg_raddr_o      = reg_raddr_q;
  assign reg_we_o         = reg_we_q;
  assign reg_waddr_o      = reg_waddr_q;
  assign reg_wdata_o      = reg_wdata_q;

  a_rd_wr_excl: assert property (@(posedge clk_i) !(mem_read_q && mem_write_q));
  a_done_busy:  assert property (@(posedge clk_i) done_q |-> busy_q);

endmodule

// File: tb/tb_mem_xfer.sv
// Self-checking bench for mem_xfer: behavioural memory/register file plus a scoreboard of
// expected read addresses, register writes and memory writes.
`timescale 1ns / 1ps

module tb_mem_xfer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  cmd;
  logic [11:0] base;
  logic [3:0]  count;
  logic [7:0]  value;
  logic        busy, done;
  logic [15:0] opcode;
  logic        mem_read;
  logic [11:0] mem_read_addr;
  logic [7:0]  mem_read_data = 8'd0;
  logic        mem_read_ack = 1'b0;
  logic        mem_write;
  logic [11:0] mem_write_addr;
  logic [7:0]  mem_write_data;
  logic [3:0]  reg_raddr;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [7:0]  reg_wdata;

  always #5 clk = ~clk;

  mem_xfer u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .cmd_i           (cmd),
    .base_i          (base),
    .count_i         (count),
    .value_i         (value),
    .busy_o          (busy),
    .done_o          (done),
    .opcode_o        (opcode),
    .mem_read_o      (mem_read),
    .mem_read_addr_o (mem_read_addr),
    .mem_read_data_i (mem_read_data),
    .mem_read_ack_i  (mem_read_ack),
    .mem_write_o     (mem_write),
    .mem_write_addr_o(mem_write_addr),
    .mem_write_data_o(mem_write_data),
    .reg_raddr_o     (reg_raddr),
    .reg_rdata_i     (reg_rdata),
    .reg_we_o        (reg_we),
    .reg_waddr_o     (reg_waddr),
    .reg_wdata_o     (reg_wdata)
  );

  // Memory and register-file models; bench pokes share the clocked write port
  logic [7:0]  mem [4096];
  logic [7:0]  regs [16];
  logic        pk_mem_we = 1'b0, pk_reg_we = 1'b0;
  logic [11:0] pk_addr = 12'd0;
  logic [7:0]  pk_data = 8'd0;

  always @(posedge clk) begin
    if (pk_mem_we) mem[pk_addr] <= pk_data;
    else if (mem_write) mem[mem_write_addr] <= mem_write_data;
    if (pk_reg_we) regs[pk_addr[3:0]] <= pk_data;
    else if (reg_we) regs[reg_waddr] <= reg_wdata;
    mem_read_ack  <= mem_read;
    mem_read_data <= mem[mem_read_addr];
  end

  assign reg_rdata = regs[reg_raddr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [11:0] exp_rd_q[$];
  logic [11:0] exp_rw_q[$];
  logic [19:0] exp_wr_q[$];
  bit          sb_en = 1'b1;
  int          cyc = 0;
  int          rw_last = -1;
  int          rw_cnt = 0;
  int          n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read && mem_write) check("rd_wr_excl", {30'd0, mem_read, mem_write}, 32'd2);
      if (mem_read && mem_read_ack && sb_en) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", {20'd0, mem_read_addr}, 32'hFFFF_FFFF);
        else check("rd_addr", {20'd0, mem_read_addr}, {20'd0, exp_rd_q.pop_front()});
      end
      if (reg_we) begin
        rw_cnt++;
        if (sb_en) begin
          if (exp_rw_q.size() == 0) check("rw_unexpected", {20'd0, reg_waddr, reg_wdata}, 32'hFFFF_FFFF);
          else check("rw_data", {20'd0, reg_waddr, reg_wdata}, {20'd0, exp_rw_q.pop_front()});
          if (rw_last >= 0) check("rw_spacing", cyc - rw_last, 4);
        end
        rw_last = cyc;
      end
      if (!busy) rw_last = -1;
      if (mem_write && sb_en) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", {12'd0, mem_write_addr, mem_write_data}, 32'hFFFF_FFFF);
        else check("wr_data", {12'd0, mem_write_addr, mem_write_data}, {12'd0, exp_wr_q.pop_front()});
      end
      if (done) n_done++;
    end
  end

  task automatic poke_mem(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk); pk_mem_we = 1'b1; pk_addr = a; pk_data = d;
    @(negedge clk); pk_mem_we = 1'b0;
  endtask

  task automatic poke_reg(input logic [3:0] i, input logic [7:0] d);
    @(negedge clk); pk_reg_we = 1'b1; pk_addr = {8'd0, i}; pk_data = d;
    @(negedge clk); pk_reg_we = 1'b0;
  endtask

  task automatic sb_empty(input string tag);
    check({tag, "_rdq"}, exp_rd_q.size(), 0);
    check({tag, "_rwq"}, exp_rw_q.size(), 0);
    check({tag, "_wrq"}, exp_wr_q.size(), 0);
  endtask

  // Issue one command; k counts edges after the start-sampling edge until done is seen
  task automatic run_cmd(input logic [1:0] c, input logic [11:0] b, input logic [3:0] n,
                         input logic [7:0] v, input int exp_cyc, input string tag);
    int k;
    bit got;
    @(negedge clk); cmd = c; base = b; count = n; value = v; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0; got = 1'b0;
    @(negedge clk); check({tag, "_busy"}, {31'd0, busy}, 1);
    while (!got && k < 400) begin
      @(posedge clk); k++;
      @(negedge clk); if (done) got = 1'b1;
    end
    check({tag, "_latency"}, k, exp_cyc);
    if (got) check({tag, "_busy_at_done"}, {31'd0, busy}, 1);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy, done}, 0);
  endtask

  initial begin
    int  k;
    bit  found;
    int  snap;
    int  d0;

    rst_n = 1'b0; start = 1'b0; cmd = 2'd0; base = 12'd0; count = 4'd0; value = 8'd0;
    poke_mem(12'h200, 8'hA2);
    poke_mem(12'h201, 8'hF0);
    poke_mem(12'hFFF, 8'h12);
    poke_mem(12'h000, 8'h34);
    for (int i = 0; i < 16; i++) poke_mem(12'h300 + 12'(i), 8'h10 + 8'(i));
    poke_mem(12'h310, 8'h77);
    poke_mem(12'h404, 8'h5A);
    @(negedge clk);
    check("rst_ctrl", {26'd0, busy, done, mem_read, mem_write, reg_we, 1'b0}, 0);
    check("rst_opcode", {16'd0, opcode}, 0);
    check("rst_addr", {mem_read_addr, mem_write_addr, reg_waddr, reg_raddr}, 0);
    check("rst_data", {16'd0, mem_write_data, reg_wdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    exp_rd_q.push_back(12'h200); exp_rd_q.push_back(12'h201);
    run_cmd(2'd0, 12'h200, 4'd0, 8'd0, 8, "fetch");
    check("fetch_opcode", {16'd0, opcode}, 32'hA2F0);
    sb_empty("fetch");

    exp_rd_q.push_back(12'hFFF); exp_rd_q.push_back(12'h000);
    run_cmd(2'd0, 12'hFFF, 4'd0, 8'd0, 8, "fetch_wrap");
    check("fetch_wrap_opcode", {16'd0, opcode}, 32'h1234);
    sb_empty("fetch_wrap");

    for (int i = 0; i < 16; i++) begin
      exp_rd_q.push_back(12'h300 + 12'(i));
      exp_rw_q.push_back({4'(i), 8'h10 + 8'(i)});
    end
    run_cmd(2'd1, 12'h300, 4'd15, 8'd0, 64, "load16");
    check("load16_opcode_kept", {16'd0, opcode}, 32'h1234);
    sb_empty("load16");

    exp_rd_q.push_back(12'h310); exp_rw_q.push_back({4'd0, 8'h77});
    run_cmd(2'd1, 12'h310, 4'd0, 8'd0, 4, "load1");
    sb_empty("load1");

    for (int i = 0; i < 4; i++) begin
      poke_reg(4'(i), 8'hF0 + 8'(i));
      exp_wr_q.push_back({12'h400 + 12'(i), 8'hF0 + 8'(i)});
    end
    run_cmd(2'd2, 12'h400, 4'd3, 8'd0, 8, "store");
    sb_empty("store");
    check("store_mem403", {24'd0, mem[12'h403]}, 32'hF3);
    check("store_mem404_untouched", {24'd0, mem[12'h404]}, 32'h5A);

    exp_wr_q.push_back({12'h500, 8'd2});
    exp_wr_q.push_back({12'h501, 8'd5});
    exp_wr_q.push_back({12'h502, 8'd4});
    run_cmd(2'd3, 12'h500, 4'd9, 8'd254, 6, "bcd254");
    sb_empty("bcd254");

    exp_wr_q.push_back({12'hFFF, 8'd0});
    exp_wr_q.push_back({12'h000, 8'd0});
    exp_wr_q.push_back({12'h001, 8'd7});
    run_cmd(2'd3, 12'hFFF, 4'd0, 8'd7, 6, "bcd7_wrap");
    sb_empty("bcd7_wrap");

    // Reset in the read phase of byte 2 of a LOAD
    sb_en = 1'b0;
    @(negedge clk); cmd = 2'd1; base = 12'h300; count = 4'd15; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0; k = 0;
    while (!found && k < 100) begin
      @(negedge clk); k++;
      if (mem_read && mem_read_addr == 12'h302) found = 1'b1;
    end
    check("rst_mid_reached", {31'd0, found}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {29'd0, busy, mem_read, reg_we}, 0);
    check("rst_mid_opcode", {16'd0, opcode}, 0);
    rst_n = 1'b1;
    snap = rw_cnt;
    repeat (20) @(negedge clk);
    check("rst_mid_no_rw", rw_cnt - snap, 0);
    check("rst_mid_idle", {31'd0, busy}, 0);
    sb_en = 1'b1;

    exp_rd_q.push_back(12'h200); exp_rd_q.push_back(12'h201);
    run_cmd(2'd0, 12'h200, 4'd0, 8'd0, 8, "fetch_after_rst");
    check("fetch_after_rst_opcode", {16'd0, opcode}, 32'hA2F0);
    sb_empty("fetch_after_rst");

    // start held high through a STORE and its DONE cycle, with cmd switched to FETCH
    for (int i = 0; i < 4; i++) begin
      poke_reg(4'(i), 8'hC0 + 8'(i));
      exp_wr_q.push_back({12'h600 + 12'(i), 8'hC0 + 8'(i)});
    end
    d0 = n_done;
    @(negedge clk); cmd = 2'd2; base = 12'h600; count = 4'd3; start = 1'b1;
    @(posedge clk); #1 cmd = 2'd0;
    found = 1'b0; k = 0;
    while (!found && k < 100) begin
      @(posedge clk); k++;
      @(negedge clk); if (done) found = 1'b1;
    end
    check("busy_start_latency", k, 8);
    @(negedge clk); start = 1'b0;
    check("busy_start_idle", {31'd0, busy}, 0);
    repeat (10) @(negedge clk);
    check("busy_start_done_count", n_done - d0, 1);
    check("busy_start_still_idle", {31'd0, busy}, 0);
    sb_empty("busy_start");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
